// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Multi-cycle fetch/decode sequencer driving the cpu datapath
//            controls; owns the program counter and retired-instruction count.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int                  WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                cu_clk,
    input  logic                cu_rst,
    input  logic                cu_run,
    output logic                cu_im_req,
    output logic [WORDSIZE-1:0] cu_im_addr,
    input  logic                cu_im_valid,
    input  logic [31:0]         cu_im_data,
    input  logic                cu_alu_zero,
    output logic [4:0]          cu_rf_addr_a,
    output logic [4:0]          cu_rf_addr_b,
    output logic [4:0]          cu_rf_write_addr,
    output logic                cu_rf_write_en,
    output logic [WORDSIZE-1:0] cu_immediate,
    output logic                cu_mux_0_sel,
    output logic                cu_mux_1_sel,
    output logic                cu_mux_2_sel,
    output logic [2:0]          cu_alu_operation,
    output logic                cu_dm_write_en,
    output logic [WORDSIZE-1:0] cu_pc,
    output logic [WORDSIZE-1:0] cu_retired,
    output logic                cu_halted
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_HALT   = 3'd6;

    localparam logic [1:0] c_K_ALU = 2'd0;
    localparam logic [1:0] c_K_LD  = 2'd1;
    localparam logic [1:0] c_K_SD  = 2'd2;
    localparam logic [1:0] c_K_BEQ = 2'd3;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;

    localparam logic [6:0] c_OP_LD   = 7'b0000011;
    localparam logic [6:0] c_OP_SD   = 7'b0100011;
    localparam logic [6:0] c_OP_ADDI = 7'b0010011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

    localparam logic [WORDSIZE-1:0] c_PC_STEP = WORDSIZE'(4);

    logic [2:0]          r_state;
    logic [1:0]          r_kind;
    logic [31:0]         r_ir;
    logic [WORDSIZE-1:0] r_pc;
    logic [WORDSIZE-1:0] r_retired;
    logic [WORDSIZE-1:0] r_im_addr;
    logic                r_im_req;
    logic                r_halted;
    logic                r_rf_we;
    logic                r_dm_we;
    logic [4:0]          r_addr_a;
    logic [4:0]          r_addr_b;
    logic [4:0]          r_waddr;
    logic [WORDSIZE-1:0] r_immediate;
    logic                r_mux_0;
    logic                r_mux_1;
    logic                r_mux_2;
    logic [2:0]          r_alu_op;

    logic                w_legal;
    logic [1:0]          w_kind;
    logic [4:0]          w_addr_a;
    logic [4:0]          w_addr_b;
    logic [4:0]          w_waddr;
    logic [WORDSIZE-1:0] w_immediate;
    logic                w_mux_0;
    logic                w_mux_1;
    logic                w_mux_2;
    logic [2:0]          w_alu_op;
    logic                w_complete;
    logic                w_taken;
    logic [WORDSIZE-1:0] w_next_pc;

    logic [6:0]          w_opcode;
    logic [2:0]          w_f3;
    logic [6:0]          w_f7;
    logic [WORDSIZE-1:0] w_imm_i;
    logic [WORDSIZE-1:0] w_imm_s;
    logic [WORDSIZE-1:0] w_imm_b;

    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];
    assign w_imm_i  = {{(WORDSIZE-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s  = {{(WORDSIZE-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b  = {{(WORDSIZE-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    // Decode of the latched instruction; consumed only on the DECODE exit edge.
    always_comb begin
        w_legal     = 1'b0;
        w_kind      = c_K_ALU;
        w_addr_a    = '0;
        w_addr_b    = '0;
        w_waddr     = '0;
        w_immediate = '0;
        w_mux_0     = 1'b0;
        w_mux_1     = 1'b0;
        w_mux_2     = 1'b0;
        w_alu_op    = c_ALU_ADD;
        case (w_opcode)
            c_OP_LD: begin
                w_legal     = (w_f3 == 3'b011);
                w_kind      = c_K_LD;
                w_addr_a    = r_ir[19:15];
                w_waddr     = r_ir[11:7];
                w_immediate = w_imm_i;
                w_mux_2     = 1'b1;
            end
            c_OP_SD: begin
                w_legal     = (w_f3 == 3'b011);
                w_kind      = c_K_SD;
                w_addr_a    = r_ir[19:15];
                w_addr_b    = r_ir[24:20];
                w_immediate = w_imm_s;
            end
            c_OP_ADDI: begin
                w_legal     = (w_f3 == 3'b000);
                w_kind      = c_K_ALU;
                w_addr_a    = r_ir[19:15];
                w_waddr     = r_ir[11:7];
                w_immediate = w_imm_i;
            end
            c_OP_R: begin
                w_kind   = c_K_ALU;
                w_addr_a = r_ir[19:15];
                w_addr_b = r_ir[24:20];
                w_waddr  = r_ir[11:7];
                w_mux_1  = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000: begin w_legal = 1'b1; w_alu_op = c_ALU_ADD; end
                        3'b110: begin w_legal = 1'b1; w_alu_op = c_ALU_OR;  end
                        3'b111: begin w_legal = 1'b1; w_alu_op = c_ALU_AND; end
                        default: w_legal = 1'b0;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_legal  = 1'b1;
                    w_alu_op = c_ALU_SUB;
                end
            end
            c_OP_BEQ: begin
                w_legal     = (w_f3 == 3'b000);
                w_kind      = c_K_BEQ;
                w_addr_a    = r_ir[19:15];
                w_addr_b    = r_ir[24:20];
                w_immediate = w_imm_b;
                w_mux_1     = 1'b1;
                w_alu_op    = c_ALU_SUB;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // The final state of each instruction path commits PC and retired count.
    always_comb begin
        w_complete = 1'b0;
        w_taken    = 1'b0;
        case (r_state)
            c_ST_EXEC: begin
                if (r_kind == c_K_BEQ) begin
                    w_complete = 1'b1;
                    w_taken    = cu_alu_zero;
                end
            end
            c_ST_MEM: w_complete = (r_kind == c_K_SD);
            c_ST_WB:  w_complete = 1'b1;
            default:  w_complete = 1'b0;
        endcase
    end

    assign w_next_pc = w_taken ? (r_pc + r_immediate) : (r_pc + c_PC_STEP);

    always_ff @(posedge cu_clk or posedge cu_rst) begin
        if (cu_rst) begin
            r_state     <= c_ST_IDLE;
            r_kind      <= c_K_ALU;
            r_ir        <= '0;
            r_pc        <= RESET_PC;
            r_retired   <= '0;
            r_im_addr   <= '0;
            r_im_req    <= 1'b0;
            r_halted    <= 1'b0;
            r_rf_we     <= 1'b0;
            r_dm_we     <= 1'b0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_waddr     <= '0;
            r_immediate <= '0;
            r_mux_0     <= 1'b0;
            r_mux_1     <= 1'b0;
            r_mux_2     <= 1'b0;
            r_alu_op    <= c_ALU_ADD;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cu_run) begin
                        r_state   <= c_ST_FETCH;
                        r_im_req  <= 1'b1;
                        r_im_addr <= r_pc;
                    end
                end
                c_ST_FETCH: begin
                    if (cu_im_valid) begin
                        r_ir     <= cu_im_data;
                        r_im_req <= 1'b0;
                        r_state  <= c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    if (w_legal) begin
                        r_kind      <= w_kind;
                        r_addr_a    <= w_addr_a;
                        r_addr_b    <= w_addr_b;
                        r_waddr     <= w_waddr;
                        r_immediate <= w_immediate;
                        r_mux_0     <= w_mux_0;
                        r_mux_1     <= w_mux_1;
                        r_mux_2     <= w_mux_2;
                        r_alu_op    <= w_alu_op;
                        r_state     <= c_ST_EXEC;
                    end else begin
                        r_halted <= 1'b1;
                        r_state  <= c_ST_HALT;
                    end
                end
                c_ST_EXEC: begin
                    case (r_kind)
                        c_K_ALU: begin
                            r_state <= c_ST_WB;
                            r_rf_we <= (r_waddr != 5'd0);
                        end
                        c_K_LD:  r_state <= c_ST_MEM;
                        c_K_SD: begin
                            r_state <= c_ST_MEM;
                            r_dm_we <= 1'b1;
                        end
                        default: r_state <= r_state;
                    endcase
                end
                c_ST_MEM: begin
                    r_dm_we <= 1'b0;
                    if (r_kind == c_K_LD) begin
                        r_state <= c_ST_WB;
                        r_rf_we <= (r_waddr != 5'd0);
                    end
                end
                c_ST_WB:   r_rf_we <= 1'b0;
                c_ST_HALT: r_state <= c_ST_HALT;
                default:   r_state <= c_ST_IDLE;
            endcase

            if (w_complete) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + WORDSIZE'(1);
                if (cu_run) begin
                    r_state   <= c_ST_FETCH;
                    r_im_req  <= 1'b1;
                    r_im_addr <= w_next_pc;
                end else begin
                    r_state <= c_ST_IDLE;
                end
            end
        end
    end

    assign cu_im_req        = r_im_req;
    assign cu_im_addr       = r_im_addr;
    assign cu_rf_addr_a     = r_addr_a;
    assign cu_rf_addr_b     = r_addr_b;
    assign cu_rf_write_addr = r_waddr;
    assign cu_rf_write_en   = r_rf_we;
    assign cu_immediate     = r_immediate;
    assign cu_mux_0_sel     = r_mux_0;
    assign cu_mux_1_sel     = r_mux_1;
    assign cu_mux_2_sel     = r_mux_2;
    assign cu_alu_operation = r_alu_op;
    assign cu_dm_write_en   = r_dm_we;
    assign cu_pc            = r_pc;
    assign cu_retired       = r_retired;
    assign cu_halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Directed self-checking bench for control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    localparam int WS = 64;

    logic          cu_clk = 1'b0;
    logic          cu_rst = 1'b0;
    logic          cu_run = 1'b0;
    logic          cu_im_req;
    logic [WS-1:0] cu_im_addr;
    logic          cu_im_valid = 1'b0;
    logic [31:0]   cu_im_data = '0;
    logic          cu_alu_zero = 1'b0;
    logic [4:0]    cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr;
    logic          cu_rf_write_en;
    logic [WS-1:0] cu_immediate;
    logic          cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel;
    logic [2:0]    cu_alu_operation;
    logic          cu_dm_write_en;
    logic [WS-1:0] cu_pc;
    logic [WS-1:0] cu_retired;
    logic          cu_halted;

    int n_pass  = 0;
    int n_total = 0;
    logic [WS-1:0] exp_pc  = '0;
    logic [WS-1:0] exp_ret = '0;

    control_unit #(.WORDSIZE(WS), .RESET_PC('0)) dut (
        .cu_clk(cu_clk), .cu_rst(cu_rst), .cu_run(cu_run),
        .cu_im_req(cu_im_req), .cu_im_addr(cu_im_addr),
        .cu_im_valid(cu_im_valid), .cu_im_data(cu_im_data),
        .cu_alu_zero(cu_alu_zero),
        .cu_rf_addr_a(cu_rf_addr_a), .cu_rf_addr_b(cu_rf_addr_b),
        .cu_rf_write_addr(cu_rf_write_addr), .cu_rf_write_en(cu_rf_write_en),
        .cu_immediate(cu_immediate),
        .cu_mux_0_sel(cu_mux_0_sel), .cu_mux_1_sel(cu_mux_1_sel), .cu_mux_2_sel(cu_mux_2_sel),
        .cu_alu_operation(cu_alu_operation), .cu_dm_write_en(cu_dm_write_en),
        .cu_pc(cu_pc), .cu_retired(cu_retired), .cu_halted(cu_halted)
    );

    always #5 cu_clk = ~cu_clk;

    task automatic tick();
        @(posedge cu_clk);
        #1;
    endtask

    // Runs one instruction from a FETCH cycle until the retired count moves (40-cycle budget).
    task automatic exec_instr(input logic [31:0] instr, input int stall, input logic zero,
                              input int drop_at, output int len, output int rf_cnt,
                              output int rf_at, output int dm_cnt, output int fetch_bad,
                              output int overlap);
        logic [WS-1:0] ret0;
        logic [WS-1:0] addr0;
        ret0 = cu_retired;
        addr0 = cu_im_addr;
        len = 0; rf_cnt = 0; rf_at = 0; dm_cnt = 0; fetch_bad = 0; overlap = 0;
        for (int c = 1; c <= 40; c++) begin
            if (cu_rf_write_en) begin rf_cnt++; rf_at = c; end
            if (cu_dm_write_en) dm_cnt++;
            if (cu_rf_write_en && cu_dm_write_en) overlap++;
            if (c <= stall + 1 && (cu_im_req !== 1'b1 || cu_im_addr !== addr0)) fetch_bad++;
            cu_im_valid = (c > stall);
            cu_im_data  = instr;
            cu_alu_zero = zero;
            if (c == drop_at) cu_run = 1'b0;
            tick();
            if (cu_retired !== ret0) begin
                len = c;
                break;
            end
        end
        cu_im_valid = 1'b0;
    endtask

    task automatic do_reset();
        cu_run = 1'b0; cu_im_valid = 1'b0; cu_im_data = '0; cu_alu_zero = 1'b0;
        #2 cu_rst = 1'b1;
        tick();
        tick();
        cu_rst = 1'b0;
        exp_pc = '0;
        exp_ret = '0;
    endtask

    task automatic test_reset();
        logic [31:0] bundle;
        do_reset();
        bundle = {cu_im_req, cu_rf_write_en, cu_dm_write_en, cu_halted, cu_rf_addr_a, cu_rf_addr_b,
                  cu_rf_write_addr, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation};
        n_total++;
        if (bundle !== '0) $display("FAIL reset_ctrl: got %h want 0", bundle); else n_pass++;
        n_total++;
        if ({cu_immediate, cu_im_addr} !== '0) $display("FAIL reset_imm_addr: got %h/%h want 0", cu_immediate, cu_im_addr); else n_pass++;
        n_total++;
        if (cu_pc !== 64'h0 || cu_retired !== 64'h0) $display("FAIL reset_pc_ret: got pc %h ret %0d want 0/0", cu_pc, cu_retired); else n_pass++;
        tick();
        n_total++;
        if (cu_im_req !== 1'b0) $display("FAIL idle_no_req: got %b want 0", cu_im_req); else n_pass++;
    endtask

    task automatic test_ld();
        int len, rf_cnt, rf_at, dm_cnt, fb, ov;
        cu_run = 1'b1;
        tick();
        n_total++;
        if (cu_im_req !== 1'b1 || cu_im_addr !== 64'h0) $display("FAIL ld_fetch_req: got req %b addr %h want 1/0", cu_im_req, cu_im_addr); else n_pass++;
        exec_instr(32'h0053B103, 0, 1'b0, 0, len, rf_cnt, rf_at, dm_cnt, fb, ov);
        exp_pc = exp_pc + 4; exp_ret = exp_ret + 1;
        n_total++;
        if (len !== 5) $display("FAIL ld_len: got %0d want 5", len); else n_pass++;
        n_total++;
        if (rf_cnt !== 1 || rf_at !== 5 || dm_cnt !== 0) $display("FAIL ld_strobes: got rf %0d@%0d dm %0d want 1@5 dm 0", rf_cnt, rf_at, dm_cnt); else n_pass++;
        n_total++;
        if (cu_rf_addr_a !== 5'd7 || cu_rf_write_addr !== 5'd2 || cu_immediate !== 64'd5)
            $display("FAIL ld_fields: got a %0d wa %0d imm %h want 7/2/5", cu_rf_addr_a, cu_rf_write_addr, cu_immediate);
        else n_pass++;
        n_total++;
        if ({cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation} !== 6'b001_000)
            $display("FAIL ld_selects: got %b want 001000", {cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation});
        else n_pass++;
        n_total++;
        if (cu_pc !== exp_pc || cu_retired !== exp_ret || cu_im_req !== 1'b1)
            $display("FAIL ld_commit: got pc %h ret %0d req %b want %h/%0d/1", cu_pc, cu_retired, cu_im_req, exp_pc, exp_ret);
        else n_pass++;
    endtask

    task automatic test_sd();
        int len, rf_cnt, rf_at, dm_cnt, fb, ov;
        exec_instr(32'h00413BA3, 0, 1'b0, 0, len, rf_cnt, rf_at, dm_cnt, fb, ov);
        exp_pc = exp_pc + 4; exp_ret = exp_ret + 1;
        n_total++;
        if (len !== 4 || dm_cnt !== 1 || rf_cnt !== 0) $display("FAIL sd_timing: got len %0d dm %0d rf %0d want 4/1/0", len, dm_cnt, rf_cnt); else n_pass++;
        n_total++;
        if (cu_rf_addr_a !== 5'd2 || cu_rf_addr_b !== 5'd4 || cu_immediate !== 64'h17)
            $display("FAIL sd_fields: got a %0d b %0d imm %h want 2/4/17", cu_rf_addr_a, cu_rf_addr_b, cu_immediate);
        else n_pass++;
        n_total++;
        if (cu_pc !== exp_pc || cu_retired !== exp_ret) $display("FAIL sd_commit: got pc %h ret %0d want %h/%0d", cu_pc, cu_retired, exp_pc, exp_ret); else n_pass++;
    endtask

    task automatic test_rtype_x0();
        int len, rf_cnt, rf_at, dm_cnt, fb, ov;
        exec_instr(32'h00208033, 0, 1'b0, 0, len, rf_cnt, rf_at, dm_cnt, fb, ov);
        exp_pc = exp_pc + 4; exp_ret = exp_ret + 1;
        n_total++;
        if (len !== 4 || rf_cnt !== 0 || dm_cnt !== 0) $display("FAIL add_x0: got len %0d rf %0d dm %0d want 4/0/0", len, rf_cnt, dm_cnt); else n_pass++;
        n_total++;
        if (cu_retired !== exp_ret || cu_pc !== exp_pc) $display("FAIL add_x0_commit: got pc %h ret %0d want %h/%0d", cu_pc, cu_retired, exp_pc, exp_ret); else n_pass++;
    endtask

    task automatic test_alu(input logic [31:0] instr, input logic [2:0] exp_op, input logic exp_m1,
                            input logic [4:0] exp_wa, input logic [WS-1:0] exp_imm);
        int len, rf_cnt, rf_at, dm_cnt, fb, ov;
        exec_instr(instr, 0, 1'b0, 0, len, rf_cnt, rf_at, dm_cnt, fb, ov);
        exp_pc = exp_pc + 4; exp_ret = exp_ret + 1;
        n_total++;
        if (len !== 4 || rf_cnt !== 1 || rf_at !== 4 || dm_cnt !== 0)
            $display("FAIL alu_timing %h: got len %0d rf %0d@%0d dm %0d want 4/1@4/0", instr, len, rf_cnt, rf_at, dm_cnt);
        else n_pass++;
        n_total++;
        if (cu_alu_operation !== exp_op || cu_mux_1_sel !== exp_m1 || cu_mux_2_sel !== 1'b0 ||
            cu_rf_write_addr !== exp_wa || cu_immediate !== exp_imm)
            $display("FAIL alu_ctrl %h: got op %b m1 %b m2 %b wa %0d imm %h want %b/%b/0/%0d/%h", instr,
                     cu_alu_operation, cu_mux_1_sel, cu_mux_2_sel, cu_rf_write_addr, cu_immediate, exp_op, exp_m1, exp_wa, exp_imm);
        else n_pass++;
        n_total++;
        if (cu_pc !== exp_pc) $display("FAIL alu_pc %h: got %h want %h", instr, cu_pc, exp_pc); else n_pass++;
    endtask

    task automatic test_beq(input logic zero, input logic [WS-1:0] exp_target);
        int len, rf_cnt, rf_at, dm_cnt, fb, ov;
        n_total++;
        if (cu_im_addr !== 64'h10) $display("FAIL beq_start_pc: got %h want 10", cu_im_addr); else n_pass++;
        exec_instr(32'hFE208CE3, 0, zero, 0, len, rf_cnt, rf_at, dm_cnt, fb, ov);
        exp_pc = exp_target; exp_ret = exp_ret + 1;
        n_total++;
        if (len !== 3 || rf_cnt !== 0 || dm_cnt !== 0) $display("FAIL beq_timing z=%b: got len %0d rf %0d dm %0d want 3/0/0", zero, len, rf_cnt, dm_cnt); else n_pass++;
        n_total++;
        if (cu_pc !== exp_pc || cu_im_addr !== exp_pc) $display("FAIL beq_target z=%b: got pc %h addr %h want %h", zero, cu_pc, cu_im_addr, exp_pc); else n_pass++;
        n_total++;
        if (cu_immediate !== 64'hFFFF_FFFF_FFFF_FFF8 || cu_alu_operation !== 3'b001 || cu_mux_1_sel !== 1'b1)
            $display("FAIL beq_ctrl: got imm %h op %b m1 %b want fff8/001/1", cu_immediate, cu_alu_operation, cu_mux_1_sel);
        else n_pass++;
    endtask

    task automatic test_stall_run_drop();
        int len, rf_cnt, rf_at, dm_cnt, fb, ov;
        exec_instr(32'h002081B3, 3, 1'b0, 6, len, rf_cnt, rf_at, dm_cnt, fb, ov);
        exp_pc = exp_pc + 4; exp_ret = exp_ret + 1;
        n_total++;
        if (fb !== 0) $display("FAIL stall_fetch_hold: got %0d unstable cycles want 0", fb); else n_pass++;
        n_total++;
        if (len !== 7 || rf_cnt !== 1 || rf_at !== 7 || ov !== 0)
            $display("FAIL stall_len: got len %0d rf %0d@%0d ov %0d want 7/1@7/0", len, rf_cnt, rf_at, ov);
        else n_pass++;
        n_total++;
        if (cu_retired !== exp_ret || cu_pc !== exp_pc || cu_im_req !== 1'b0)
            $display("FAIL run_drop_commit: got pc %h ret %0d req %b want %h/%0d/0", cu_pc, cu_retired, cu_im_req, exp_pc, exp_ret);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (cu_im_req !== 1'b0 || cu_pc !== exp_pc) $display("FAIL idle_after_drop: got req %b pc %h want 0/%h", cu_im_req, cu_pc, exp_pc); else n_pass++;
    endtask

    task automatic test_illegal_halt();
        int bad;
        cu_run = 1'b1;
        tick();
        n_total++;
        if (cu_im_req !== 1'b1 || cu_im_addr !== exp_pc) $display("FAIL ill_fetch: got req %b addr %h want 1/%h", cu_im_req, cu_im_addr, exp_pc); else n_pass++;
        cu_im_valid = 1'b1;
        cu_im_data  = 32'hFFFF_FFFF;
        tick();
        cu_im_valid = 1'b0;
        tick();
        n_total++;
        if (cu_halted !== 1'b1) $display("FAIL halted_flag: got %b want 1", cu_halted); else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cu_im_valid = 1'b1;
            if (cu_im_req !== 1'b0 || cu_rf_write_en !== 1'b0 || cu_dm_write_en !== 1'b0 ||
                cu_pc !== exp_pc || cu_retired !== exp_ret || cu_halted !== 1'b1) bad++;
            tick();
        end
        cu_im_valid = 1'b0;
        n_total++;
        if (bad !== 0) $display("FAIL halt_frozen: got %0d bad cycles want 0", bad); else n_pass++;
        cu_run = 1'b0;
        #2 cu_rst = 1'b1;
        #1;
        n_total++;
        if ({cu_halted, cu_im_req, cu_rf_write_en, cu_dm_write_en, cu_rf_addr_a, cu_rf_addr_b,
             cu_rf_write_addr, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation} !== '0 ||
            cu_immediate !== '0 || cu_im_addr !== '0 || cu_pc !== '0 || cu_retired !== '0)
            $display("FAIL halt_async_reset: got halted %b pc %h ret %0d imm %h want all 0", cu_halted, cu_pc, cu_retired, cu_immediate);
        else n_pass++;
        tick();
        cu_rst = 1'b0;
        exp_pc = '0;
        exp_ret = '0;
    endtask

    task automatic test_reset_mid_instr();
        cu_run = 1'b1;
        tick();
        cu_im_valid = 1'b1;
        cu_im_data  = 32'h0053B103;
        tick();
        cu_im_valid = 1'b0;
        tick();
        tick();
        tick();
        n_total++;
        if (cu_rf_write_en !== 1'b1) $display("FAIL mid_wb_strobe: got %b want 1", cu_rf_write_en); else n_pass++;
        #2 cu_rst = 1'b1;
        #1;
        n_total++;
        if (cu_rf_write_en !== 1'b0 || cu_pc !== 64'h0 || cu_retired !== 64'h0)
            $display("FAIL mid_reset_abort: got we %b pc %h ret %0d want 0/0/0", cu_rf_write_en, cu_pc, cu_retired);
        else n_pass++;
        cu_run = 1'b0;
        tick();
        cu_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ld();
        test_sd();
        test_rtype_x0();
        test_alu(32'hFFF00293, 3'b000, 1'b0, 5'd5, {WS{1'b1}});
        test_beq(1'b1, 64'h08);
        test_alu(32'h402081B3, 3'b001, 1'b1, 5'd3, '0);
        test_alu(32'h0020E1B3, 3'b011, 1'b1, 5'd3, '0);
        test_beq(1'b0, 64'h14);
        test_alu(32'h0020F1B3, 3'b010, 1'b1, 5'd3, '0);
        test_stall_run_drop();
        test_illegal_halt();
        test_reset_mid_instr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
